// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: bus-written byte FIFO feeding an 8N1 serial transmitter (8E1 when UART_TX_PARITY_EN is defined).
// Latency: byte written at edge E0 is popped at E0+1 with the start bit low from then; frame = 10*CLK_DIV (+CLK_DIV parity) + 1 idle clock.
// Backpressure: none toward the bus; a write into a full FIFO (with no same-edge pop) is dropped and sets sticky overflow.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wen,
    input  logic        ren,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        uart_tx
);
    // FIFO_DEPTH must be a power of two so the pointers wrap for free.
    localparam int AW = $clog2(FIFO_DEPTH);
    // A divider of 1 still needs a one-bit counter that simply stays at 0.
    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE    = BW'(1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [AW:0]   CNT_ONE     = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
`endif

    logic       full;
    logic       empty;
    logic       busy;
    logic       push_req;
    logic       push;
    logic       pop;
    logic       drop;
    logic       status_rd;
    logic [7:0] head;
    logic [7:0] count_lo;
    logic       unused_data_hi;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign busy      = (state != ST_IDLE) || !empty;
    assign head      = mem[rd_ptr];
    assign count_lo  = 8'(count);

    // The transmitter pops whenever it sits idle with data waiting.
    assign pop       = (state == ST_IDLE) && !empty;
    // A full FIFO still takes a write if the head leaves on the same edge.
    assign push_req  = wen && (address == 2'd0);
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && !push;
    assign status_rd = ren && (address == 2'd0);

    // Only the low byte of a write carries data.
    assign unused_data_hi = ^data_in[31:8];

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    // Pointer and occupancy tracking; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Sticky overflow: a drop on the same edge as a status read wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (status_rd) begin
            overflow <= 1'b0;
        end
    end

    // Register read mux; returns zero whenever the block is not selected for read.
    always_comb begin
        data_out = '0;
        if (ren) begin
            case (address)
                2'd0:    data_out = {28'b0, overflow, busy, full, empty};
                2'd1:    data_out = {24'b0, count_lo};
                default: data_out = '0;
            endcase
        end
    end

    // Transmit FSM: each state holds its line level for CLK_DIV clocks, the baud
    // counter reloads on every state or bit entry, and uart_tx is registered so
    // reset drives the line high asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    uart_tx <= 1'b1;
                    if (!empty) begin
                        shreg    <= head;
`ifdef UART_TX_PARITY_EN
                        par_bit  <= ^head;
`endif
                        baud_cnt <= BAUD_RELOAD;
                        uart_tx  <= 1'b0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_cnt  <= '0;
                        uart_tx  <= shreg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            uart_tx <= par_bit;
                            state   <= ST_PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= ST_STOP;
`endif
                        end else begin
                            shreg   <= {1'b0, shreg[7:1]};
                            uart_tx <= shreg[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        uart_tx  <= 1'b1;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    uart_tx <= 1'b1;
                    if (baud_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: drives bus writes/reads and decodes the serial line against a cycle-level reference model.
// Latency: every expected frame carries the clock at which its start bit must appear.
// Backpressure: the model decides acceptance/drop from FIFO occupancy at each write edge.
module tb_uart_tx_fifo;
    localparam int CLK_DIV    = 4;
    localparam int DEPTH      = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CLK_DIV;

    logic        clk;
    logic        reset;
    logic        wen;
    logic        ren;
    logic [1:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        uart_tx;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wen      (wen),
        .ren      (ren),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .uart_tx  (uart_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b1;

    typedef struct {
        logic [7:0] b;
        int         pop;
    } exp_t;

    exp_t expq[$];
    int   pend[$];
    bit   has_last = 1'b0;
    int   last_pop = 0;
    bit   m_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Entries still in the FIFO after edge t: those whose pop edge is later.
    function automatic int cnt_gt(input int t);
        int n = 0;
        foreach (pend[i]) if (pend[i] > t) n++;
        return n;
    endfunction

    // Busy while any accepted byte is queued or its frame has not finished.
    function automatic bit busy_at(input int t);
        bit b = 1'b0;
        foreach (pend[i]) if (pend[i] + FRAME > t) b = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] model_read(input bit r, input logic [1:0] a, input int t);
        int n;
        n = cnt_gt(t);
        if (!r) return 32'h0;
        if (a == 2'd0) return {28'b0, m_ovf, busy_at(t), (n == DEPTH), (n == 0)};
        if (a == 2'd1) return 32'(n);
        return 32'h0;
    endfunction

    task automatic model_edge(input bit w, input bit r, input logic [1:0] a, input logic [7:0] d, input int e);
        bit drop = 1'b0;
        int p;
        if (w && a == 2'd0) begin
            if (cnt_gt(e) < DEPTH) begin
                p = e + 1;
                if (has_last && (last_pop + FRAME + 1 > p)) p = last_pop + FRAME + 1;
                has_last = 1'b1;
                last_pop = p;
                pend.push_back(p);
                expq.push_back('{b: d, pop: p});
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (r && a == 2'd0) m_ovf = 1'b0;
        while (pend.size() > 0 && pend[0] + FRAME < e - 1) void'(pend.pop_front());
    endtask

    task automatic model_reset();
        pend.delete();
        expq.delete();
        has_last = 1'b0;
        m_ovf = 1'b0;
    endtask

    // One bus cycle: entered just after a rising edge, returns just after the next.
    task automatic step(input bit w, input bit r, input logic [1:0] a, input logic [7:0] d);
        wen = w;
        ren = r;
        address = a;
        data_in = {24'($urandom), d};
        @(negedge clk);
        check("data_out", data_out, model_read(r, a, cyc));
        @(posedge clk);
        #1;
        model_edge(w, r, a, d, cyc);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic drain();
        int g = 0;
        while ((expq.size() != 0 || busy_at(cyc)) && g < 3000) begin
            idle();
            g++;
        end
        check("drain_done", 32'(g < 3000), 32'h1);
    endtask

    // Serial decoder: samples every clock of every bit slot and matches the frame
    // against the oldest expected byte, including the clock its start bit began.
    task automatic decode_frame();
        int         st;
        logic [10:0] bits;
        bit         glitch;
        bit         aborted;
        exp_t       e;
        st = cyc;
        bits = '0;
        glitch = 1'b0;
        aborted = 1'b0;
        for (int s = 0; s < FB && !aborted; s++) begin
            for (int j = 0; j < CLK_DIV && !aborted; j++) begin
                if (s != 0 || j != 0) begin
                    @(negedge clk);
                    if (!mon_en) aborted = 1'b1;
                end
                if (!aborted) begin
                    if (j == 0) bits[s] = uart_tx;
                    else if (uart_tx !== bits[s]) glitch = 1'b1;
                end
            end
        end
        if (aborted) return;
        if (expq.size() == 0) begin
            check("frame_unexpected", 32'h1, 32'h0);
        end else begin
            e = expq.pop_front();
            check("frame_data", {24'b0, bits[8:1]}, {24'b0, e.b});
            check("frame_start_cycle", 32'(st), 32'(e.pop));
            check("frame_shape", {29'b0, glitch, bits[0], bits[FB-1]}, 32'h1);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", {31'b0, bits[9]}, {31'b0, ^e.b});
`endif
        end
    endtask

    initial begin
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && (uart_tx === 1'b0)) decode_frame();
            prev = uart_tx;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        int g;
        bit stay_high;
        clk = 1'b0;
        reset = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        address = 2'd0;
        data_in = '0;

        // Reset state
        #1;
        check("reset_line", {31'b0, uart_tx}, 32'h1);
        ren = 1'b1;
        #1;
        check("reset_status", data_out, 32'h1);
        address = 2'd1;
        #1;
        check("reset_count", data_out, 32'h0);
        ren = 1'b0;
        #1;
        check("no_ren_zero", data_out, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single byte, then idle status
        step(1'b1, 1'b0, 2'd0, 8'h55);
        drain();
        step(1'b0, 1'b1, 2'd0, 8'h00);

        // Back-to-back bytes with count reads
        step(1'b1, 1'b0, 2'd0, 8'hA3);
        step(1'b1, 1'b1, 2'd1, 8'h0F);
        step(1'b0, 1'b1, 2'd1, 8'h00);
        drain();

        // Overflow: six writes while the first frame is in flight, two status reads
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'd0, 8'(8'h30 + i));
        step(1'b0, 1'b1, 2'd0, 8'h00);
        step(1'b0, 1'b1, 2'd0, 8'h00);

        // Push on the exact edge the full FIFO pops its head
        tgt = 0;
        foreach (pend[i]) if (tgt == 0 && pend[i] > cyc) tgt = pend[i];
        g = 0;
        while (cyc < tgt - 1 && g < 1000) begin
            idle();
            g++;
        end
        step(1'b1, 1'b0, 2'd0, 8'h99);
        step(1'b0, 1'b1, 2'd0, 8'h00);
        step(1'b0, 1'b1, 2'd1, 8'h00);
        drain();

        // Odd-parity-count byte (parity bit checked when parity is built in)
        step(1'b1, 1'b0, 2'd0, 8'h07);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit w;
            bit r;
            logic [1:0] a;
            w = ($urandom % 9) == 0;
            r = ($urandom % 3) == 0;
            a = (($urandom % 4) == 0) ? 2'($urandom) : 2'd0;
            if (!w && r) a = 2'($urandom);
            step(w, r, a, 8'($urandom));
        end
        drain();

        // Reset in the middle of data bit 3
        step(1'b1, 1'b0, 2'd0, 8'hF0);
        step(1'b1, 1'b0, 2'd0, 8'h11);
        step(1'b1, 1'b0, 2'd0, 8'h22);
        tgt = expq[0].pop + CLK_DIV * 4 + CLK_DIV / 2;
        g = 0;
        while (cyc < tgt && g < 1000) begin
            idle();
            g++;
        end
        check("line_before_reset", {31'b0, uart_tx}, 32'h0);
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        check("line_in_reset", {31'b0, uart_tx}, 32'h1);
        ren = 1'b1;
        address = 2'd1;
        #1;
        check("count_in_reset", data_out, 32'h0);
        address = 2'd0;
        #1;
        check("status_in_reset", data_out, 32'h1);
        ren = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        stay_high = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            idle();
            if (uart_tx !== 1'b1) stay_high = 1'b0;
        end
        check("no_edges_after_reset", {31'b0, stay_high}, 32'h1);

        // Recovery after reset
        step(1'b1, 1'b0, 2'd0, 8'h3C);
        drain();
        check("scoreboard_empty", 32'(expq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
